// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the core and host ports.
// Bounded bursts, a combinational grant, and read data routed back to its owner one cycle later.
module data_mem_arbiter #(
   parameter int unsigned ADDR_W    = 9,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic              core_gnt,
   output logic              core_stall,
   output logic              core_rvalid,
   output logic [DATA_W-1:0] core_rdata,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned     CNT_W   = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      OWN_IDLE = 2'd0,
      OWN_CORE = 2'd1,
      OWN_HOST = 2'd2
   } owner_e;

   owner_e           owner_q, owner_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rd_core_q, rd_core_d;
   logic             rd_host_q, rd_host_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q   <= OWN_IDLE;
         cnt_q     <= '0;
         rd_core_q <= 1'b0;
         rd_host_q <= 1'b0;
      end else begin
         owner_q   <= owner_d;
         cnt_q     <= cnt_d;
         rd_core_q <= rd_core_d;
         rd_host_q <= rd_host_d;
      end
   end

   always_comb begin
      core_gnt = 1'b0;
      host_gnt = 1'b0;
      if (core_req && host_req) begin
         // Contention: the current owner keeps the port until its burst count saturates.
         unique case (owner_q)
            OWN_CORE: begin
               if (cnt_q < CNT_MAX) core_gnt = 1'b1;
               else                 host_gnt = 1'b1;
            end
            OWN_HOST: begin
               if (cnt_q < CNT_MAX) host_gnt = 1'b1;
               else                 core_gnt = 1'b1;
            end
            default: core_gnt = 1'b1;
         endcase
      end else begin
         core_gnt = core_req;
         host_gnt = host_req;
      end
   end

   always_comb begin
      owner_d   = owner_q;
      cnt_d     = cnt_q;
      rd_core_d = core_gnt & ~core_we;
      rd_host_d = host_gnt & ~host_we;
      if (core_gnt) begin
         if (owner_q == OWN_CORE) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
         end else begin
            owner_d = OWN_CORE;
            cnt_d   = CNT_ONE;
         end
      end else if (host_gnt) begin
         if (owner_q == OWN_HOST) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
         end else begin
            owner_d = OWN_HOST;
            cnt_d   = CNT_ONE;
         end
      end else begin
         owner_d = OWN_IDLE;
         cnt_d   = '0;
      end
   end

   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (core_gnt) begin
         mem_addr  = core_addr;
         mem_we    = core_we;
         mem_wdata = core_wdata;
      end else if (host_gnt) begin
         mem_addr  = host_addr;
         mem_we    = host_we;
         mem_wdata = host_wdata;
      end
   end

   assign core_stall  = core_req & ~core_gnt;
   assign core_rvalid = rd_core_q;
   assign host_rvalid = rd_host_q;
   assign core_rdata  = rd_core_q ? mem_rdata : '0;
   assign host_rdata  = rd_host_q ? mem_rdata : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter.
// A behavioural sync-read memory sits on the memory port, and expected read data is queued per owner.
module tb_data_mem_arbiter;

   localparam int unsigned MAXB = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        core_req, core_we, core_gnt, core_stall, core_rvalid;
   logic [8:0]  core_addr;
   logic [15:0] core_wdata, core_rdata;
   logic        host_req, host_we, host_gnt, host_rvalid;
   logic [8:0]  host_addr;
   logic [15:0] host_wdata, host_rdata;
   logic [8:0]  mem_addr;
   logic        mem_we;
   logic [15:0] mem_wdata, mem_rdata;

   data_mem_arbiter #(.ADDR_W(9), .DATA_W(16), .MAX_BURST(MAXB)) dut (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   logic [15:0] env_mem [512];
   logic [15:0] ref_mem [512];
   always @(posedge clk) begin
      if (mem_we) env_mem[mem_addr] <= mem_wdata;
      mem_rdata <= env_mem[mem_addr];
   end

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [15:0] q_core [$];
   logic [15:0] q_host [$];
   int          m_owner;   // 0 idle, 1 core, 2 host
   int          m_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = 0;
      m_cnt   = 0;
      q_core.delete();
      q_host.delete();
   endtask

   // Starts at posedge+1, checks at the negedge, returns at the next posedge+1.
   task automatic step(input logic creq, input logic cwe, input logic [8:0] caddr, input logic [15:0] cwd,
                       input logic hreq, input logic hwe, input logic [8:0] haddr, input logic [15:0] hwd,
                       output logic gc_seen, output logic ec, output logic eh);
      logic [15:0] exp_d;
      core_req = creq; core_we = cwe; core_addr = caddr; core_wdata = cwd;
      host_req = hreq; host_we = hwe; host_addr = haddr; host_wdata = hwd;
      ec = 1'b0;
      eh = 1'b0;
      if (creq && hreq) begin
         if (m_owner == 0)      ec = 1'b1;
         else if (m_owner == 1) begin if (m_cnt < int'(MAXB)) ec = 1'b1; else eh = 1'b1; end
         else                   begin if (m_cnt < int'(MAXB)) eh = 1'b1; else ec = 1'b1; end
      end else begin
         ec = creq;
         eh = hreq;
      end
      #4;
      chk("core_rvalid", 32'(core_rvalid), 32'(q_core.size() != 0));
      if (q_core.size() != 0) begin
         exp_d = q_core.pop_front();
         chk("core_rdata", 32'(core_rdata), 32'(exp_d));
      end else chk("core_rdata_idle", 32'(core_rdata), 32'h0);
      chk("host_rvalid", 32'(host_rvalid), 32'(q_host.size() != 0));
      if (q_host.size() != 0) begin
         exp_d = q_host.pop_front();
         chk("host_rdata", 32'(host_rdata), 32'(exp_d));
      end else chk("host_rdata_idle", 32'(host_rdata), 32'h0);
      chk("core_gnt", 32'(core_gnt), 32'(ec));
      chk("host_gnt", 32'(host_gnt), 32'(eh));
      chk("core_stall", 32'(core_stall), 32'(creq & ~ec));
      chk("mem_addr", 32'(mem_addr), ec ? 32'(caddr) : eh ? 32'(haddr) : 32'h0);
      chk("mem_we", 32'(mem_we), 32'((ec & cwe) | (eh & hwe)));
      chk("mem_wdata", 32'(mem_wdata), ec ? 32'(cwd) : eh ? 32'(hwd) : 32'h0);
      gc_seen = core_gnt;
      if (ec) begin
         if (!cwe) q_core.push_back(ref_mem[caddr]); else ref_mem[caddr] = cwd;
         if (m_owner == 1) m_cnt = (m_cnt < int'(MAXB)) ? m_cnt + 1 : m_cnt;
         else begin m_owner = 1; m_cnt = 1; end
      end else if (eh) begin
         if (!hwe) q_host.push_back(ref_mem[haddr]); else ref_mem[haddr] = hwd;
         if (m_owner == 2) m_cnt = (m_cnt < int'(MAXB)) ? m_cnt + 1 : m_cnt;
         else begin m_owner = 2; m_cnt = 1; end
      end else begin
         m_owner = 0;
         m_cnt   = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_step();
      logic g, a, b;
      step(1'b0, 1'b0, 9'h0, 16'h0, 1'b0, 1'b0, 9'h0, 16'h0, g, a, b);
   endtask

   initial begin
      logic g, ec, eh;
      logic cr, cw, hr, hw;
      logic [8:0]  ca, ha;
      logic [15:0] cd, hd;
      logic pat [10];
      logic [9:0] pat_bits;

      for (int i = 0; i < 512; i++) begin
         env_mem[i] = 16'(i * 37) ^ 16'hA5A5;
         ref_mem[i] = env_mem[i];
      end
      env_mem[5] = 16'h1234;
      ref_mem[5] = 16'h1234;
      model_reset();

      // Reset with both requesting
      rst = 1'b1;
      core_req = 1'b1; core_we = 1'b0; core_addr = 9'h001; core_wdata = '0;
      host_req = 1'b1; host_we = 1'b0; host_addr = 9'h002; host_wdata = '0;
      #3;
      chk("rst_core_rvalid", 32'(core_rvalid), 32'h0);
      chk("rst_host_rvalid", 32'(host_rvalid), 32'h0);
      @(posedge clk); #1;
      chk("rst_core_rvalid_edge", 32'(core_rvalid), 32'h0);
      chk("rst_host_rvalid_edge", 32'(host_rvalid), 32'h0);
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      rst = 1'b0;
      step(1'b1, 1'b0, 9'h001, 16'h0, 1'b1, 1'b0, 9'h002, 16'h0, g, ec, eh);
      chk("t1_core_first", 32'(g), 32'h1);
      idle_step();
      idle_step();

      // Core read of 0x005 returns 0x1234
      step(1'b1, 1'b0, 9'h005, 16'h0, 1'b0, 1'b0, 9'h0, 16'h0, g, ec, eh);
      chk("t2_core_gnt", 32'(g), 32'h1);
      idle_step();

      // Continuous contention
      pat_bits = 10'b1100001111;   // bit i = core granted in cycle i
      for (int i = 0; i < 10; i++) pat[i] = pat_bits[i];
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0, 9'h020, 16'h0, 1'b1, 1'b0, 9'h030, 16'h0, g, ec, eh);
         chk($sformatf("t3_pattern_%0d", i), 32'(g), 32'(pat[i]));
      end
      idle_step();
      idle_step();

      // Host write to top address, then read it back through the core
      step(1'b0, 1'b0, 9'h0, 16'h0, 1'b1, 1'b1, 9'h1FF, 16'hBEEF, g, ec, eh);
      idle_step();
      step(1'b1, 1'b0, 9'h1FF, 16'h0, 1'b0, 1'b0, 9'h0, 16'h0, g, ec, eh);
      idle_step();

      // Alternating single-owner reads
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0)
            step(1'b1, 1'b0, 9'($urandom_range(0, 511)), 16'h0, 1'b0, 1'b0, 9'h0, 16'h0, g, ec, eh);
         else
            step(1'b0, 1'b0, 9'h0, 16'h0, 1'b1, 1'b0, 9'($urandom_range(0, 511)), 16'h0, g, ec, eh);
      end
      idle_step();

      // Random mixed traffic; a denied requester holds its request
      cr = 1'b0; hr = 1'b0; cw = 1'b0; hw = 1'b0; ca = '0; ha = '0; cd = '0; hd = '0;
      ec = 1'b0; eh = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (!(cr && !ec)) begin
            cr = ($urandom_range(0, 3) != 0); cw = $urandom_range(0, 1) == 1;
            ca = 9'($urandom_range(0, 511)); cd = 16'($urandom);
         end
         if (!(hr && !eh)) begin
            hr = ($urandom_range(0, 3) != 0); hw = $urandom_range(0, 2) == 0;
            ha = 9'($urandom_range(0, 511)); hd = 16'($urandom);
         end
         step(cr, cw, ca, cd, hr, hw, ha, hd, g, ec, eh);
      end
      idle_step();

      // Reset the cycle after a granted host read discards its return
      step(1'b0, 1'b0, 9'h0, 16'h0, 1'b1, 1'b0, 9'h044, 16'h0, g, ec, eh);
      core_req = 1'b0; host_req = 1'b0;
      rst = 1'b1;
      #1;
      chk("t6_host_rvalid", 32'(host_rvalid), 32'h0);
      chk("t6_host_rdata", 32'(host_rdata), 32'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      idle_step();
      step(1'b1, 1'b0, 9'h010, 16'h0, 1'b1, 1'b0, 9'h011, 16'h0, g, ec, eh);
      chk("t6_idle_core_first", 32'(g), 32'h1);
      idle_step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
